// File: rtl/pmu_multicore_quota.sv
// Per-core PMU quota monitor: one shared CLEAR/ACCUM/PUBLISH round sums masked counters per core.
// Build option QUOTA_INTR_LATCH_EN selects sticky (clearable) interrupts instead of level interrupts.
module pmu_multicore_quota #(
  parameter int REG_WIDTH  = 32,
  parameter int N_COUNTERS = 9,
  parameter int N_CORES    = 4,
  localparam int MAX_WIDTH = REG_WIDTH + $clog2(N_COUNTERS + 1)
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            softrst_i,
  input  logic [N_COUNTERS*REG_WIDTH-1:0] counter_value_i,
  input  logic [N_CORES*N_COUNTERS-1:0]   quota_mask_i,
  input  logic [N_CORES*MAX_WIDTH-1:0]    quota_limit_i,
  input  logic [N_CORES-1:0]              intr_clr_i,
  output logic [N_CORES*MAX_WIDTH-1:0]    quota_sum_o,
  output logic [N_CORES-1:0]              sum_valid_o,
  output logic [N_CORES-1:0]              intr_quota_o
);

  localparam int IDX_W = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COUNTERS - 1);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  state_t                                  state_r;
  logic [IDX_W-1:0]                        idx_r;
  logic [N_CORES-1:0][MAX_WIDTH-1:0]       acc_r;
  logic [N_CORES-1:0][MAX_WIDTH-1:0]       sum_r;
  logic [N_CORES-1:0][N_COUNTERS-1:0]      mask_r;
  logic [N_CORES-1:0]                      invalid_r;
  logic [N_CORES-1:0]                      valid_r;
  logic [N_CORES-1:0]                      intr_r;

  logic [MAX_WIDTH-1:0]                    sample_s;
  logic [N_CORES-1:0][N_COUNTERS-1:0]      mask_s;
  logic [N_CORES-1:0][MAX_WIDTH-1:0]       limit_s;
  logic [N_CORES-1:0][MAX_WIDTH-1:0]       addend_s;
  logic [N_CORES-1:0]                      changed_s;
  logic [N_CORES-1:0]                      publish_s;
  logic [N_CORES-1:0]                      exceed_s;
  logic [N_CORES-1:0]                      intr_next_s;

  // Live counter selected by the current step index, zero-extended to accumulator width.
  always_comb begin
    sample_s = '0;
    for (int k = 0; k < N_COUNTERS; k++) begin
      if (idx_r == IDX_W'(k)) begin
        sample_s = {{(MAX_WIDTH-REG_WIDTH){1'b0}}, counter_value_i[k*REG_WIDTH +: REG_WIDTH]};
      end else begin
        sample_s = sample_s;
      end
    end
  end

  // Per-core unpacking, mask-change detection, addend selection and publish qualification.
  always_comb begin
    mask_s    = '0;
    limit_s   = '0;
    addend_s  = '0;
    changed_s = '0;
    publish_s = '0;
    exceed_s  = '0;
    for (int c = 0; c < N_CORES; c++) begin
      mask_s[c]    = quota_mask_i[c*N_COUNTERS +: N_COUNTERS];
      limit_s[c]   = quota_limit_i[c*MAX_WIDTH +: MAX_WIDTH];
      changed_s[c] = (mask_s[c] != mask_r[c]);
      if (mask_s[c][idx_r]) begin
        addend_s[c] = sample_s;
      end else begin
        addend_s[c] = '0;
      end
      // A mask edit seen during the publish cycle itself still voids this round.
      publish_s[c] = (state_r == ST_PUBLISH) && !invalid_r[c] && !changed_s[c];
      exceed_s[c]  = (acc_r[c] > limit_s[c]);
    end
  end

  // Next interrupt state; only a valid publish may change the evaluated condition.
  always_comb begin
    intr_next_s = intr_r;
    for (int c = 0; c < N_CORES; c++) begin
`ifdef QUOTA_INTR_LATCH_EN
      if (publish_s[c] && exceed_s[c]) begin
        intr_next_s[c] = 1'b1;
      end else if (intr_clr_i[c]) begin
        intr_next_s[c] = 1'b0;
      end else begin
        intr_next_s[c] = intr_r[c];
      end
`else
      if (publish_s[c]) begin
        intr_next_s[c] = exceed_s[c];
      end else begin
        intr_next_s[c] = intr_r[c];
      end
`endif
    end
  end

`ifndef QUOTA_INTR_LATCH_EN
  logic unused_clr_s;
  assign unused_clr_s = ^intr_clr_i;
`endif

  // Round sequencer, accumulators, published sums and interrupt registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= ST_CLEAR;
      idx_r     <= '0;
      acc_r     <= '0;
      sum_r     <= '0;
      mask_r    <= '0;
      invalid_r <= '0;
      valid_r   <= '0;
      intr_r    <= '0;
    end else if (softrst_i) begin
      state_r   <= ST_CLEAR;
      idx_r     <= '0;
      acc_r     <= '0;
      sum_r     <= '0;
      mask_r    <= '0;
      invalid_r <= '0;
      valid_r   <= '0;
      intr_r    <= '0;
    end else begin
      mask_r  <= mask_s;
      valid_r <= '0;
      intr_r  <= intr_next_s;
      case (state_r)
        ST_CLEAR: begin
          acc_r     <= '0;
          idx_r     <= '0;
          // A mask that differs at round start (e.g. right after reset) voids this round.
          invalid_r <= changed_s;
          state_r   <= ST_ACCUM;
        end
        ST_ACCUM: begin
          for (int c = 0; c < N_CORES; c++) begin
            if (invalid_r[c] || changed_s[c]) begin
              acc_r[c] <= '0;
            end else begin
              acc_r[c] <= acc_r[c] + addend_s[c];
            end
          end
          invalid_r <= invalid_r | changed_s;
          if (idx_r == LAST_IDX) begin
            idx_r   <= '0;
            state_r <= ST_PUBLISH;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            state_r <= ST_ACCUM;
          end
        end
        ST_PUBLISH: begin
          for (int c = 0; c < N_CORES; c++) begin
            if (publish_s[c]) begin
              sum_r[c]   <= acc_r[c];
              valid_r[c] <= 1'b1;
            end else begin
              sum_r[c]   <= sum_r[c];
              valid_r[c] <= 1'b0;
            end
          end
          invalid_r <= invalid_r | changed_s;
          idx_r     <= '0;
          state_r   <= ST_CLEAR;
        end
        default: begin
          idx_r   <= '0;
          state_r <= ST_CLEAR;
        end
      endcase
    end
  end

  assign quota_sum_o  = sum_r;
  assign sum_valid_o  = valid_r;
  assign intr_quota_o = intr_r;

endmodule

// File: tb/tb_pmu_multicore_quota.sv
// Scoreboard bench for pmu_multicore_quota (4 counters, 2 cores, 32-bit counters, 6-cycle round).
module tb_pmu_multicore_quota;

  localparam int MW = 35;

  typedef struct {
    logic [MW-1:0] sum;
    logic          intr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          softrst = 1'b0;
  logic [127:0]  counter_value = '0;
  logic [7:0]    quota_mask = '0;
  logic [69:0]   quota_limit = '0;
  logic [1:0]    intr_clr = '0;
  logic [69:0]   quota_sum;
  logic [1:0]    sum_valid;
  logic [1:0]    intr_quota;

  int   checks = 0;
  int   failures = 0;
  int   pulses0 = 0;
  int   pulses1 = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t e0;
  exp_t e1;

  pmu_multicore_quota #(.REG_WIDTH(32), .N_COUNTERS(4), .N_CORES(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .softrst_i(softrst),
    .counter_value_i(counter_value), .quota_mask_i(quota_mask),
    .quota_limit_i(quota_limit), .intr_clr_i(intr_clr),
    .quota_sum_o(quota_sum), .sum_valid_o(sum_valid), .intr_quota_o(intr_quota)
  );

  always #5 clk = ~clk;

  // Scoreboard: every sum_valid pulse pops and compares the oldest expected publish.
  always @(negedge clk) begin
    if (sum_valid[0] === 1'b1) begin
      pulses0++;
      checks++;
      if (exp_q0.size() == 0) begin
        failures++;
        $display("FAIL pub_unexpected core0 got sum=%0h intr=%b want no publish", quota_sum[34:0], intr_quota[0]);
      end else begin
        e0 = exp_q0.pop_front();
        if (quota_sum[34:0] !== e0.sum || intr_quota[0] !== e0.intr) begin
          failures++;
          $display("FAIL pub core0 got sum=%0h intr=%b want sum=%0h intr=%b", quota_sum[34:0], intr_quota[0], e0.sum, e0.intr);
        end
      end
    end
    if (sum_valid[1] === 1'b1) begin
      pulses1++;
      checks++;
      if (exp_q1.size() == 0) begin
        failures++;
        $display("FAIL pub_unexpected core1 got sum=%0h intr=%b want no publish", quota_sum[69:35], intr_quota[1]);
      end else begin
        e1 = exp_q1.pop_front();
        if (quota_sum[69:35] !== e1.sum || intr_quota[1] !== e1.intr) begin
          failures++;
          $display("FAIL pub core1 got sum=%0h intr=%b want sum=%0h intr=%b", quota_sum[69:35], intr_quota[1], e1.sum, e1.intr);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] c0, c1, c2, c3, input logic [3:0] m0, m1,
                       input logic [MW-1:0] l0, l1);
    counter_value = {c3, c2, c1, c0};
    quota_mask    = {m1, m0};
    quota_limit   = {l1, l0};
  endtask

  task automatic push0(input logic [MW-1:0] s, input logic i);
    exp_q0.push_back('{sum: s, intr: i});
  endtask

  task automatic push1(input logic [MW-1:0] s, input logic i);
    exp_q1.push_back('{sum: s, intr: i});
  endtask

  // Soft reset for two cycles; returns on the negedge where it is released.
  task automatic start();
    @(negedge clk);
    softrst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    softrst = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 4'h0, 4'h0, 35'd0, 35'd0);
    rstn = 1'b0;
    #3;
    checks++;
    if (quota_sum !== 70'd0 || sum_valid !== 2'b00 || intr_quota !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs got sum=%0h valid=%b intr=%b want 0/00/00", quota_sum, sum_valid, intr_quota);
    end
    cycles(2);
    push0(35'd0, 1'b0);
    push1(35'd0, 1'b0);
    rstn = 1'b1;
    cnt = 0;
    while (cnt < 30 && sum_valid[0] !== 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 6) begin
      failures++;
      $display("FAIL first_publish_zero_mask got %0d cycles want 6", cnt);
    end
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL reset_drain got pending=%0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_basic();
    drive(32'd10, 32'd20, 32'd30, 32'd40, 4'b1111, 4'b0101, 35'd99, 35'd39);
    push0(35'd100, 1'b1);
    push1(35'd40, 1'b1);
    start();
    cycles(13);
    checks++;
    if (intr_quota !== 2'b11) begin
      failures++;
      $display("FAIL basic_intr got %b want 11", intr_quota);
    end
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL basic_drain got pending=%0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_equal_and_zero_mask();
    drive(32'd25, 32'd25, 32'd25, 32'd25, 4'b1111, 4'b0000, 35'd100, 35'd0);
    push0(35'd100, 1'b0);
    push1(35'd0, 1'b0);
    push1(35'd0, 1'b0);
    start();
    cycles(13);
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL equal_drain got pending=%0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_max();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, 4'b1111,
          35'h3_FFFF_FFFB, 35'h3_FFFF_FFFC);
    push0(35'h3_FFFF_FFFC, 1'b1);
    push1(35'h3_FFFF_FFFC, 1'b0);
    start();
    cycles(13);
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL max_drain got pending=%0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_mask_change();
    int p0;
    int p1;
    drive(32'd1, 32'd2, 32'd4, 32'd8, 4'b1111, 4'b0011, 35'd14, 35'd10);
    push0(35'd15, 1'b1);
    push0(35'd15, 1'b1);
    push0(35'd15, 1'b1);
    push1(35'd3, 1'b0);
    start();
    cycles(14);
    p0 = pulses0;
    p1 = pulses1;
    quota_mask[7:4] = 4'b1100;
    push1(35'd12, 1'b1);
    cycles(5);
    checks++;
    if (pulses1 !== p1 || pulses0 !== p0 + 1) begin
      failures++;
      $display("FAIL mask_change_round got pulses=%0d/%0d want %0d/%0d", pulses0 - p0, pulses1 - p1, 1, 0);
    end
    cycles(6);
    checks++;
    if (pulses1 !== p1 + 1) begin
      failures++;
      $display("FAIL mask_change_next got core1 pulses=%0d want 1", pulses1 - p1);
    end
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL mask_change_drain got pending=%0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_intr();
    drive(32'd50, 32'd50, 32'd0, 32'd0, 4'b0011, 4'b0000, 35'd60, 35'd0);
    push0(35'd100, 1'b1);
    push1(35'd0, 1'b0);
    push1(35'd0, 1'b0);
    push1(35'd0, 1'b0);
`ifdef QUOTA_INTR_LATCH_EN
    push0(35'd2, 1'b1);
    push0(35'd100, 1'b1);
    push1(35'd0, 1'b0);
`else
    push0(35'd2, 1'b0);
`endif
    start();
    cycles(12);
    counter_value[63:0] = {32'd1, 32'd1};
`ifndef QUOTA_INTR_LATCH_EN
    intr_clr[0] = 1'b1;
    @(negedge clk);
    intr_clr[0] = 1'b0;
    checks++;
    if (intr_quota[0] !== 1'b1) begin
      failures++;
      $display("FAIL level_clr_ignored got %b want 1", intr_quota[0]);
    end
    cycles(5);
    checks++;
    if (intr_quota[0] !== 1'b0) begin
      failures++;
      $display("FAIL level_drop got %b want 0", intr_quota[0]);
    end
`else
    cycles(6);
    checks++;
    if (intr_quota[0] !== 1'b1) begin
      failures++;
      $display("FAIL latch_hold got %b want 1", intr_quota[0]);
    end
    intr_clr[0] = 1'b1;
    @(negedge clk);
    intr_clr[0] = 1'b0;
    checks++;
    if (intr_quota[0] !== 1'b0) begin
      failures++;
      $display("FAIL latch_clear got %b want 0", intr_quota[0]);
    end
    counter_value[63:0] = {32'd50, 32'd50};
    cycles(4);
    intr_clr[0] = 1'b1;
    @(negedge clk);
    intr_clr[0] = 1'b0;
    checks++;
    if (intr_quota[0] !== 1'b1) begin
      failures++;
      $display("FAIL latch_set_wins got %b want 1", intr_quota[0]);
    end
`endif
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL intr_drain got pending=%0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_reset_midaccum();
    int cnt;
    drive(32'd10, 32'd20, 32'd30, 32'd40, 4'b1111, 4'b0101, 35'd99, 35'd39);
    push0(35'd100, 1'b1);
    push1(35'd40, 1'b1);
    start();
    cycles(15);
    checks++;
    if (quota_sum[34:0] !== 35'd100) begin
      failures++;
      $display("FAIL pre_reset_sum got %0d want 100", quota_sum[34:0]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (quota_sum !== 70'd0 || sum_valid !== 2'b00 || intr_quota !== 2'b00) begin
      failures++;
      $display("FAIL async_reset_outputs got sum=%0h valid=%b intr=%b want 0/00/00", quota_sum, sum_valid, intr_quota);
    end
    @(negedge clk);
    push0(35'd100, 1'b1);
    push1(35'd40, 1'b1);
    rstn = 1'b1;
    cnt = 0;
    while (cnt < 30 && sum_valid[0] !== 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 12) begin
      failures++;
      $display("FAIL hard_reset_restart got %0d cycles want 12", cnt);
    end
    cycles(3);
    softrst = 1'b1;
    @(negedge clk);
    checks++;
    if (quota_sum !== 70'd0 || sum_valid !== 2'b00 || intr_quota !== 2'b00) begin
      failures++;
      $display("FAIL soft_reset_outputs got sum=%0h valid=%b intr=%b want 0/00/00", quota_sum, sum_valid, intr_quota);
    end
    push0(35'd100, 1'b1);
    push1(35'd40, 1'b1);
    softrst = 1'b0;
    cnt = 0;
    while (cnt < 30 && sum_valid[0] !== 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 12) begin
      failures++;
      $display("FAIL soft_reset_restart got %0d cycles want 12", cnt);
    end
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_drain got pending=%0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_equal_and_zero_mask();
    test_max();
    test_mask_change();
    test_intr();
    test_reset_midaccum();
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
